// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are registered before the ALU, and the result is held until the consumer takes it.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_sel,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_sel,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [3:0]   alu_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [N-1:0] res_out,
  output logic         res_zero,
  output logic         res_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic           rr_ptr_r;
  logic           grant_s;
  logic           accept_s;
  logic [3:0]     op_sel_r;
  logic [N-1:0]   op_a_r, op_b_r;
  logic           op_id_r;

  function automatic logic sel_illegal(input logic [3:0] sel);
    case (sel)
      4'b0010, 4'b0110, 4'b0000, 4'b0001: sel_illegal = 1'b0;
      default:                            sel_illegal = 1'b1;
    endcase
  endfunction

  assign alu_sel = op_sel_r;
  assign alu_a   = op_a_r;
  assign alu_b   = op_b_r;

  // Grant selection: a lone requester wins, otherwise rr_ptr breaks the tie.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = rr_ptr_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state and ready generation; readies are only offered in IDLE and never during reset.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept_s   = 1'b1;
          req0_ready = ~grant_s;
          req1_ready = grant_s;
          state_s    = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = DONE;
      DONE: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand registers and round-robin pointer, loaded on an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sel_r <= 4'b0000;
      op_a_r   <= {N{1'b0}};
      op_b_r   <= {N{1'b0}};
      op_id_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else if (accept_s) begin
      op_sel_r <= grant_s ? req1_sel : req0_sel;
      op_a_r   <= grant_s ? req1_a   : req0_a;
      op_b_r   <= grant_s ? req1_b   : req0_b;
      op_id_r  <= grant_s;
      rr_ptr_r <= ~grant_s;
    end
  end

  // Result capture at the end of EXEC; held until the consumer takes it in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_out   <= {N{1'b0}};
      res_zero  <= 1'b0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state_r)
        EXEC: begin
          res_valid <= 1'b1;
          res_out   <= alu_out;
          res_zero  <= alu_zero;
          res_id    <= op_id_r;
          res_err   <= sel_illegal(op_sel_r);
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter; contains a simple ALU stand-in and a
// transaction-level reference model compared against the DUT on every falling edge.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]   req0_sel, req1_sel, alu_sel;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, res_out;
  logic         alu_zero, res_valid, res_ready, res_id, res_zero, res_err;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_out(res_out),
    .res_zero(res_zero), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    case (alu_sel)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stage 0 = free, 1 = op in flight, 2 = result held.
  int           m_stage;
  bit           m_rr, m_id, m_zero, m_err, m_rid, acc0, acc1;
  logic [3:0]   m_sel;
  logic [N-1:0] m_a, m_b, m_out;

  int gtime[16];
  int gwho[16];
  int ng;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_result(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
    if (s == 4'd2) return a + b;
    if (s == 4'd6) return a - b;
    if (s == 4'd0) return a & b;
    if (s == 4'd1) return a | b;
    return '0;
  endfunction

  function automatic bit is_legal(input logic [3:0] s);
    return (s == 4'd2) || (s == 4'd6) || (s == 4'd0) || (s == 4'd1);
  endfunction

  task automatic model_reset();
    m_stage = 0; m_rr = 1'b0; m_id = 1'b0; m_sel = '0; m_a = '0; m_b = '0;
    m_out = '0; m_zero = 1'b0; m_err = 1'b0; m_rid = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic check_outputs();
    bit e0, e1;
    e0 = !rst && m_stage == 0 && req0_valid && (!req1_valid || !m_rr);
    e1 = !rst && m_stage == 0 && req1_valid && (!req0_valid || m_rr);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("alu_sel", alu_sel, m_sel);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("res_valid", res_valid, m_stage == 2);
    chk("res_out", res_out, m_out);
    chk("res_zero", res_zero, m_zero);
    chk("res_id", res_id, m_rid);
    chk("res_err", res_err, m_err);
  endtask

  task automatic model_edge();
    bit g;
    acc0 = 1'b0; acc1 = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_stage == 0) begin
      if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? m_rr : req1_valid;
        m_sel = g ? req1_sel : req0_sel;
        m_a = g ? req1_a : req0_a;
        m_b = g ? req1_b : req0_b;
        m_id = g; m_rr = !g; m_stage = 1;
        if (g) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end else if (m_stage == 1) begin
      m_out = ref_result(m_sel, m_a, m_b);
      m_zero = (m_out == '0);
      m_err = !is_legal(m_sel);
      m_rid = m_id;
      m_stage = 2;
    end else if (res_ready) begin
      m_stage = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [3:0] rand_sel();
    logic [3:0] s;
    case ($urandom_range(0, 4))
      0: s = 4'b0010;
      1: s = 4'b0110;
      2: s = 4'b0000;
      3: s = 4'b0001;
      default: s = 4'($urandom_range(0, 15));
    endcase
    return s;
  endfunction

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0;
    model_reset();
    chk("model_sub_wrap", ref_result(4'b0110, 32'd0, 32'd1), 32'hFFFF_FFFF);
    step(); step();
    rst = 1'b0;

    // Single add from requester 0
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_sel = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
    #1 chk("t1_ready", req0_ready, 1'b1);
    step(); req0_valid = 1'b0;
    chk("t1_exec_alu_a", alu_a, 32'd5);
    step();
    chk("t1_valid", res_valid, 1'b1); chk("t1_out", res_out, 32'd12);
    chk("t1_zero", res_zero, 1'b0); chk("t1_id", res_id, 1'b0); chk("t1_err", res_err, 1'b0);
    step();

    // Subtract to zero, then wrap-around, from requester 1
    req1_valid = 1'b1; req1_sel = 4'b0110; req1_a = 32'd9; req1_b = 32'd9;
    step(); req1_valid = 1'b0; step();
    chk("t2_out", res_out, 32'd0); chk("t2_zero", res_zero, 1'b1); chk("t2_id", res_id, 1'b1);
    step();
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd1;
    step(); req1_valid = 1'b0; step();
    chk("t2_wrap_out", res_out, 32'hFFFF_FFFF); chk("t2_wrap_zero", res_zero, 1'b0);
    step();

    // Continuous contention with the consumer always ready
    req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    req1_valid = 1'b1; req1_sel = 4'b0001; req1_a = 32'h1;    req1_b = 32'h2;
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req0_ready && ng < 16) begin gtime[ng] = k; gwho[ng] = 0; ng++; end
      if (req1_ready && ng < 16) begin gtime[ng] = k; gwho[ng] = 1; ng++; end
      if (res_valid) chk("t3_result", res_out, res_id ? 32'h3 : 32'hF0);
      step();
    end
    chk("t3_grant_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant_order", gwho[k], k % 2);
      if (k > 0) chk("t3_spacing", gtime[k] - gtime[k-1], 3);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();

    // Back-pressure on the result
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_sel = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
    step(); req0_valid = 1'b0; step();
    req1_valid = 1'b1; req1_sel = 4'b0000; req1_a = 32'hFF; req1_b = 32'h0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_ready1", req1_ready, 1'b0);
      chk("t4_hold_out", res_out, 32'd2);
      chk("t4_hold_valid", res_valid, 1'b1);
      step();
    end
    res_ready = 1'b1;
    step();
    #1 chk("t4_regrant", req1_ready, 1'b1);
    step(); req1_valid = 1'b0; step();
    chk("t4_out", res_out, 32'h0F); chk("t4_id", res_id, 1'b1);
    step();

    // Illegal select
    req0_valid = 1'b1; req0_sel = 4'b1111; req0_a = 32'd3; req0_b = 32'd4;
    step(); req0_valid = 1'b0; step();
    chk("t5_out", res_out, 32'd0); chk("t5_zero", res_zero, 1'b1); chk("t5_err", res_err, 1'b1);
    step();

    // Asynchronous reset while a result is held
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_sel = 4'b0010; req0_a = 32'd4; req0_b = 32'd4;
    step(); req0_valid = 1'b0; step();
    chk("t6_pre_valid", res_valid, 1'b1);
    req0_valid = 1'b1; req0_sel = 4'b0010; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_sel = 4'b0001; req1_a = 32'd1;  req1_b = 32'd2;
    #2 rst = 1'b1; model_reset();
    #1 chk("t6_valid_drop", res_valid, 1'b0);
    chk("t6_ready0_in_rst", req0_ready, 1'b0); chk("t6_ready1_in_rst", req1_ready, 1'b0);
    step();
    rst = 1'b0;
    #1 chk("t6_grant0", req0_ready, 1'b1); chk("t6_nogrant1", req1_ready, 1'b0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0; step();
    chk("t6_id", res_id, 1'b0); chk("t6_out", res_out, 32'd30);
    res_ready = 1'b1;
    step();

    // Randomised traffic with the model checking every cycle
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; model_reset();
        step();
        rst = 1'b0;
      end
      if (acc0 || !req0_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          req0_valid = 1'b1; req0_sel = rand_sel(); req0_a = $urandom;
          req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
        end else begin
          req0_valid = 1'b0;
        end
      end
      if (acc1 || !req1_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          req1_valid = 1'b1; req1_sel = rand_sel(); req1_a = $urandom;
          req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
        end else begin
          req1_valid = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
